// File: rtl/line_buffer_reader_pkg.sv
// Shared types and widths for the line buffer reader.
package line_buffer_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int ADDR_W  = 12;
    localparam int BYTE_W  = 8;
    localparam int PIXEL_W = 16;

endpackage

// File: rtl/line_buffer_reader_byte_fifo.sv
// Small first-word-fall-through byte FIFO; rd_data shows the head entry whenever not empty.
module byte_fifo
    import line_buffer_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          push,
    input  logic [BYTE_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [BYTE_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [BYTE_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/line_buffer_reader.sv
// Scans one line of a byte RAM into 16-bit pixels through a small FIFO.
// Optional DOUBLE_BUFFER_EN: alternate RAM banks per line via ramAddress[11].
module line_buffer_reader
    import line_buffer_reader_pkg::*;
#(
    parameter int LINE_BYTES = 2048,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                lineStart,
    output logic [ADDR_W-1:0]   ramAddress,
    input  logic [BYTE_W-1:0]   ramData,
    output logic [PIXEL_W-1:0]  pixelData,
    output logic                pixelValid,
    input  logic                pixelReady,
    output logic                busy,
    output logic                lineDone,
    output logic                startIgnored
);

`ifdef DOUBLE_BUFFER_EN
    localparam int MAX_LINE = 2048;
`else
    localparam int MAX_LINE = 4096;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    generate
        if (LINE_BYTES < 2 || LINE_BYTES > MAX_LINE || (LINE_BYTES % 2) != 0) begin : g_bad_line
            $error("line_buffer_reader: LINE_BYTES out of range or odd");
        end
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("line_buffer_reader: FIFO_DEPTH must be a power of two >= 4");
        end
    endgenerate

    state_t             state_reg;
    logic [ADDR_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               busy_reg;
    logic               ign_reg;
    logic               p1_reg;        // address on the bus this cycle
    logic               p2_reg;        // its data on ramData this cycle
    logic [BYTE_W-1:0]  even_reg;
    logic               even_valid_reg;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BYTE_W-1:0]  fifo_head;
    logic [CNT_W:0]     pending;
    logic               room;
    logic               accept;
    logic               issue;
    logic               last_issue;
    logic               pix_valid;
    logic               pix_xfer;
    logic               fifo_pop;
    logic               last_pixel;
    logic [ADDR_W-1:0]  cnt_now;
    logic [ADDR_W-1:0]  issue_addr;

    // Reserve FIFO space for every read still travelling through the RAM.
    assign pending    = {1'b0, fifo_count} + (CNT_W+1)'(p1_reg) + (CNT_W+1)'(p2_reg);
    assign room       = !fifo_full && (pending < (CNT_W+1)'(FIFO_DEPTH));
    assign accept     = (state_reg == IDLE) && lineStart;
    assign issue      = accept || ((state_reg == READ) && room);
    assign last_issue = (state_reg == READ) && room && (cnt_reg == ADDR_W'(LINE_BYTES - 1));
    assign cnt_now    = accept ? '0 : cnt_reg;

    // Even byte waits in even_reg; the odd byte is the FIFO head until accepted.
    assign pix_valid  = even_valid_reg && !fifo_empty;
    assign pix_xfer   = pix_valid && pixelReady;
    assign fifo_pop   = (!even_valid_reg && !fifo_empty) || pix_xfer;
    assign last_pixel = (state_reg == DRAIN) && pix_xfer && !p1_reg && !p2_reg
                        && (fifo_count == CNT_W'(1));

`ifdef DOUBLE_BUFFER_EN
    logic bank_reg;
    logic bank_next;

    assign bank_next = accept ? ~bank_reg : bank_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bank_reg <= 1'b0;
        end else begin
            bank_reg <= bank_next;
        end
    end

    assign issue_addr = {bank_next, cnt_now[ADDR_W-2:0]};
`else
    assign issue_addr = cnt_now;
`endif

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetN  (resetN),
        .push    (p2_reg),
        .wr_data (ramData),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            busy_reg       <= 1'b0;
            ign_reg        <= 1'b0;
            p1_reg         <= 1'b0;
            p2_reg         <= 1'b0;
            even_reg       <= '0;
            even_valid_reg <= 1'b0;
        end else begin
            ign_reg <= lineStart && (state_reg != IDLE);
            p1_reg  <= issue;
            p2_reg  <= p1_reg;
            if (issue) begin
                addr_reg <= issue_addr;
                cnt_reg  <= cnt_now + ADDR_W'(1);
            end
            if (!even_valid_reg && !fifo_empty) begin
                even_reg       <= fifo_head;
                even_valid_reg <= 1'b1;
            end else if (pix_xfer) begin
                even_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= READ;
                        busy_reg  <= 1'b1;
                    end
                end
                READ: begin
                    if (last_issue) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pixel) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ramAddress   = addr_reg;
    assign pixelData    = pix_valid ? {even_reg, fifo_head} : '0;
    assign pixelValid   = pix_valid;
    assign busy         = busy_reg;
    assign lineDone     = last_pixel;
    assign startIgnored = ign_reg;

endmodule
